// File: rtl/simon_pkg.sv
// Shared Simon key-schedule definitions: z sequences, variant tables and FSM state type.
package simon_pkg;

  // Element j of each sequence sits at bit [61-j] (first published bit is the MSB).
  localparam logic [61:0] Z_SEQ [0:4] = '{
    62'b11111010001001010110000111001101111101000100101011000011100110,
    62'b10001110111110010011000010110101000111011111001001100001011010,
    62'b10101111011100000011010010011000101000010001111110010110110011,
    62'b11011011101011000110010111100000010010001010011100110100001111,
    62'b11010001111001101011011000100000010111000011001010010011101111
  };

  typedef enum logic {IDLE, EMIT} state_e;

  function automatic bit simon_legal(input int n, input int m);
    return (n == 16 && m == 4) || (n == 24 && (m == 3 || m == 4)) ||
           (n == 32 && (m == 3 || m == 4)) || (n == 48 && (m == 2 || m == 3)) ||
           (n == 64 && (m >= 2 && m <= 4));
  endfunction

  function automatic int simon_rounds(input int n, input int m);
    if (n == 16) return 32;
    if (n == 24) return (m == 3) ? 36 : 36;
    if (n == 32) return (m == 3) ? 42 : 44;
    if (n == 48) return (m == 2) ? 52 : 54;
    if (n == 64) return (m == 2) ? 68 : ((m == 3) ? 69 : 72);
    return 0;
  endfunction

  function automatic int simon_zidx(input int n, input int m);
    if (n == 16) return 0;
    if (n == 24) return (m == 3) ? 0 : 1;
    if (n == 32) return (m == 3) ? 2 : 3;
    if (n == 48) return (m == 2) ? 2 : 3;
    if (n == 64) return (m == 2) ? 2 : ((m == 3) ? 3 : 4);
    return 0;
  endfunction

endpackage

// File: rtl/simon_key_expand_if.sv
// Control and round-key stream bundle between key-load logic, expander and key consumer.
interface simon_key_expand_if #(
    parameter int N = 64,
    parameter int M = 4
);
    logic           start;
    logic [N*M-1:0] key;
    logic           abort;
    logic           busy;
    logic           done;
    logic           rk_valid;
    logic           rk_ready;
    logic [N-1:0]   rk_data;
    logic [6:0]     rk_idx;

    modport master (output start, key, abort, rk_ready,
                    input  busy, done, rk_valid, rk_data, rk_idx);
    modport slave  (input  start, key, abort, rk_ready,
                    output busy, done, rk_valid, rk_data, rk_idx);
endinterface

// File: rtl/simon_key_round.sv
// One Simon key-schedule step: derives word i+M from the current M-word window.
module simon_key_round #(
    parameter int N = 64,
    parameter int M = 4
) (
    input  logic [N-1:0] w0_i,
    input  logic [N-1:0] w1_i,
    input  logic [N-1:0] wlast_i,
    input  logic         zbit_i,
    output logic [N-1:0] next_o
);
    // Only the four-word schedule folds w[1] into the rotation term.
    localparam logic [N-1:0] W1_MASK = (M == 4) ? '1 : '0;

    logic [N-1:0] t0;
    logic [N-1:0] t1;

    assign t0     = {wlast_i[2:0], wlast_i[N-1:3]} ^ (w1_i & W1_MASK);
    assign t1     = t0 ^ {t0[0], t0[N-1:1]};
    assign next_o = ~w0_i ^ t1 ^ {{(N-1){1'b0}}, zbit_i} ^ N'(3);
endmodule

// File: rtl/simon_key_expand.sv
// Simon key expander: latches the master key on start and streams k[0]..k[T-1] over valid/ready.
import simon_pkg::*;

module simon_key_expand #(
    parameter int N = 64,
    parameter int M = 4
) (
    input logic                clk,
    input logic                res,
    simon_key_expand_if.slave  bus
);
    localparam int          T        = simon_rounds(N, M);
    localparam int          ZIDX     = simon_zidx(N, M);
    localparam logic [61:0] ZS       = Z_SEQ[ZIDX];
    localparam logic [6:0]  LAST_IDX = 7'(T - 1);

    if (!simon_legal(N, M)) begin : g_bad_pair
        $error("simon_key_expand: unsupported (N,M) pair");
    end

    state_e       state_q, state_d;
    logic [N-1:0] w_q [M];
    logic [N-1:0] w_d [M];
    logic [6:0]   idx_q, idx_d;
    logic [5:0]   zpos_q, zpos_d;
    logic         done_q, done_d;
    logic [N-1:0] next_w;
    logic         zbit;

    assign zbit = ZS[6'd61 - zpos_q];

    simon_key_round #(.N(N), .M(M)) u_round (
        .w0_i    (w_q[0]),
        .w1_i    (w_q[1]),
        .wlast_i (w_q[M-1]),
        .zbit_i  (zbit),
        .next_o  (next_w)
    );

    always_ff @(posedge clk or posedge res) begin
        if (res) begin
            state_q <= IDLE;
            idx_q   <= '0;
            zpos_q  <= '0;
            done_q  <= 1'b0;
            for (int j = 0; j < M; j++) w_q[j] <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            zpos_q  <= zpos_d;
            done_q  <= done_d;
            w_q     <= w_d;
        end
    end

    always_comb begin
        state_d = state_q;
        w_d     = w_q;
        idx_d   = idx_q;
        zpos_d  = zpos_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (bus.start && !bus.abort) begin
                    for (int j = 0; j < M; j++) w_d[j] = bus.key[j*N +: N];
                    idx_d   = '0;
                    zpos_d  = '0;
                    state_d = EMIT;
                end
            end
            EMIT: begin
                if (bus.abort) begin
                    state_d = IDLE;
                end else if (bus.rk_ready) begin
                    if (idx_q == LAST_IDX) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end else begin
                        // Slide the window; the z position wraps mod 62 alongside rk_idx.
                        for (int j = 0; j < M - 1; j++) w_d[j] = w_q[j+1];
                        w_d[M-1] = next_w;
                        idx_d    = idx_q + 7'd1;
                        zpos_d   = (zpos_q == 6'd61) ? 6'd0 : zpos_q + 6'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.busy     = (state_q == EMIT);
    assign bus.rk_valid = (state_q == EMIT);
    assign bus.rk_data  = w_q[0];
    assign bus.rk_idx   = idx_q;
    assign bus.done     = done_q;
endmodule

// File: tb/tb_simon_key_expand.sv
// Randomised self-checking bench for simon_key_expand over three (N,M) variants.
module tb_simon_key_expand;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         res;
    int           vec = 0;
    int           errs = 0;
    int           sel;
    logic         start_b, abort_b, ready_b;
    logic [255:0] key_b;
    logic [63:0]  got_k [0:71];
    logic [63:0]  exp_k [0:71];

    localparam int CN [3] = '{16, 64, 32};
    localparam int CM [3] = '{4, 4, 3};
    localparam int CT [3] = '{32, 72, 42};
    localparam int CZ [3] = '{0, 4, 2};
    localparam bit [0:61] ZT [5] = '{
        62'b11111010001001010110000111001101111101000100101011000011100110,
        62'b10001110111110010011000010110101000111011111001001100001011010,
        62'b10101111011100000011010010011000101000010001111110010110110011,
        62'b11011011101011000110010111100000010010001010011100110100001111,
        62'b11010001111001101011011000100000010111000011001010010011101111
    };

    simon_key_expand_if #(.N(16), .M(4)) if16 ();
    simon_key_expand_if #(.N(64), .M(4)) if64 ();
    simon_key_expand_if #(.N(32), .M(3)) if32 ();

    simon_key_expand #(.N(16), .M(4)) dut16 (.clk(clk), .res(res), .bus(if16));
    simon_key_expand #(.N(64), .M(4)) dut64 (.clk(clk), .res(res), .bus(if64));
    simon_key_expand #(.N(32), .M(3)) dut32 (.clk(clk), .res(res), .bus(if32));

    assign if16.start    = (sel == 0) ? start_b : 1'b0;
    assign if64.start    = (sel == 1) ? start_b : 1'b0;
    assign if32.start    = (sel == 2) ? start_b : 1'b0;
    assign if16.abort    = (sel == 0) ? abort_b : 1'b0;
    assign if64.abort    = (sel == 1) ? abort_b : 1'b0;
    assign if32.abort    = (sel == 2) ? abort_b : 1'b0;
    assign if16.rk_ready = (sel == 0) ? ready_b : 1'b0;
    assign if64.rk_ready = (sel == 1) ? ready_b : 1'b0;
    assign if32.rk_ready = (sel == 2) ? ready_b : 1'b0;
    assign if16.key      = key_b[63:0];
    assign if64.key      = key_b;
    assign if32.key      = key_b[95:0];

    logic        obs_busy, obs_done, obs_valid;
    logic [63:0] obs_data;
    logic [6:0]  obs_idx;

    always_comb begin
        obs_busy = 1'b0; obs_done = 1'b0; obs_valid = 1'b0; obs_data = '0; obs_idx = '0;
        case (sel)
            0: begin obs_busy = if16.busy; obs_done = if16.done; obs_valid = if16.rk_valid;
                     obs_data = 64'(if16.rk_data); obs_idx = if16.rk_idx; end
            1: begin obs_busy = if64.busy; obs_done = if64.done; obs_valid = if64.rk_valid;
                     obs_data = if64.rk_data; obs_idx = if64.rk_idx; end
            2: begin obs_busy = if32.busy; obs_done = if32.done; obs_valid = if32.rk_valid;
                     obs_data = 64'(if32.rk_data); obs_idx = if32.rk_idx; end
            default: ;
        endcase
    end

    function automatic logic [63:0] wmask(input int n);
        return (n == 64) ? '1 : ((64'd1 << n) - 64'd1);
    endfunction

    function automatic logic [63:0] ror(input logic [63:0] x, input int r, input int n);
        return ((x >> r) | (x << (n - r))) & wmask(n);
    endfunction

    // Reference schedule written directly as k[i] from k[i-1], k[i-3], k[i-m] and z[i-m].
    task automatic model(input int s, input logic [255:0] k);
        int n, m;
        logic [63:0] tmp;
        n = CN[s];
        m = CM[s];
        for (int j = 0; j < m; j++) exp_k[j] = 64'(k >> (j * n)) & wmask(n);
        for (int i = m; i < CT[s]; i++) begin
            tmp = ror(exp_k[i-1], 3, n);
            if (m == 4) tmp ^= exp_k[i-3];
            tmp ^= ror(tmp, 1, n);
            exp_k[i] = (~exp_k[i-m] ^ tmp ^ 64'(ZT[CZ[s]][(i-m) % 62]) ^ 64'd3) & wmask(n);
        end
    endtask

    task automatic encrypt(input int n, input int t, input logic [63:0] px, input logic [63:0] py,
                           output logic [63:0] cx, output logic [63:0] cy);
        logic [63:0] x, y, tmp;
        x = px;
        y = py;
        for (int r = 0; r < t; r++) begin
            tmp = x;
            x = y ^ (ror(x, n - 1, n) & ror(x, n - 8, n)) ^ ror(x, n - 2, n) ^ got_k[r];
            y = tmp;
        end
        cx = x;
        cy = y;
    endtask

    // Drives one expansion on the selected DUT, capturing every handshaken key into got_k.
    task automatic collect(input logic [255:0] k, input bit do_start, input int pct,
                           input int abort_at, input int poke_at, input bit chain,
                           input logic [255:0] k2, output int ntx, output int ndone,
                           output int end_cyc);
        int cyc;
        bit pv;
        logic [63:0] pd;
        logic [6:0]  pi;
        ntx = 0; ndone = 0; end_cyc = 0; pv = 1'b0; pd = '0; pi = '0;
        if (do_start) begin
            @(posedge clk); #1; start_b = 1'b1; key_b = k;
        end
        @(posedge clk); #1; start_b = 1'b0;
        cyc = 1;
        while (cyc < 3000) begin
            start_b = 1'b0;
            abort_b = 1'b0;
            if (obs_done) ndone++;
            if (cyc == 1) begin
                vec++;
                if (obs_valid !== 1'b1 || obs_idx !== 7'd0) begin
                    errs++; $display("FAIL first_key: valid=%b idx=%0d, required valid=1 idx=0", obs_valid, obs_idx);
                end
            end
            if (pv) begin
                vec++;
                if ({obs_valid, obs_idx, obs_data} !== {1'b1, pi, pd}) begin
                    errs++; $display("FAIL stall_hold: valid=%b idx=%0d data=%0h, required 1 %0d %0h",
                                     obs_valid, obs_idx, obs_data, pi, pd);
                end
            end
            if (!obs_busy) begin
                end_cyc = cyc;
                if (chain) begin start_b = 1'b1; key_b = k2; end
                break;
            end
            if (cyc == poke_at) begin start_b = 1'b1; key_b = ~k; end
            ready_b = ($urandom_range(0, 99) < pct);
            if (obs_valid && 32'(obs_idx) == abort_at) begin abort_b = 1'b1; ready_b = 1'b0; end
            pv = obs_valid && !ready_b && !abort_b;
            if (obs_valid && ready_b) begin
                vec++;
                if (32'(obs_idx) != ntx) begin
                    errs++; $display("FAIL idx_order: idx=%0d, required %0d", obs_idx, ntx);
                end
                if (ntx < 72) got_k[ntx] = obs_data;
                ntx++;
            end
            pd = obs_data;
            pi = obs_idx;
            @(posedge clk); #1; cyc++;
        end
        if (end_cyc == 0) begin
            vec++; errs++; $display("FAIL collect_timeout: busy=%b after %0d cycles, required 0", obs_busy, cyc);
        end
    endtask

    task automatic test_reset();
        for (int s = 0; s < 3; s++) begin
            sel = s; #1;
            vec++;
            if ({obs_busy, obs_done, obs_valid, obs_idx, obs_data} !== '0) begin
                errs++; $display("FAIL reset_state[%0d]: busy=%b done=%b valid=%b idx=%0d data=%0h, required all 0",
                                 s, obs_busy, obs_done, obs_valid, obs_idx, obs_data);
            end
        end
    endtask

    task automatic test_n16();
        int ntx, nd, ec;
        logic [63:0] cx, cy;
        logic [15:0] first [4] = '{16'h0100, 16'h0908, 16'h1110, 16'h1918};
        sel = 0;
        model(0, 256'h1918_1110_0908_0100);
        collect(256'h1918_1110_0908_0100, 1'b1, 100, -1, -1, 1'b0, '0, ntx, nd, ec);
        vec++; if (ntx != 32) begin errs++; $display("FAIL n16_count: %0d transfers, required 32", ntx); end
        vec++; if (nd != 1 || ec != 33) begin errs++; $display("FAIL n16_done: %0d pulses at cycle %0d, required 1 at 33", nd, ec); end
        for (int i = 0; i < 4; i++) begin
            vec++; if (got_k[i] !== 64'(first[i])) begin errs++; $display("FAIL n16_rk%0d: got %0h required %0h", i, got_k[i], first[i]); end
        end
        for (int i = 0; i < 32; i++) begin
            vec++; if (got_k[i] !== exp_k[i]) begin errs++; $display("FAIL n16_key[%0d]: got %0h required %0h", i, got_k[i], exp_k[i]); end
        end
        encrypt(16, 32, 64'h6565, 64'h6877, cx, cy);
        vec++; if ({cx, cy} !== {64'hc69b, 64'he9bb}) begin errs++; $display("FAIL n16_cipher: got %0h_%0h required c69b_e9bb", cx, cy); end
    endtask

    task automatic test_n64();
        int ntx, nd, ec;
        logic [63:0] cx, cy;
        logic [255:0] k = 256'h1f1e1d1c1b1a1918_1716151413121110_0f0e0d0c0b0a0908_0706050403020100;
        sel = 1;
        model(1, k);
        collect(k, 1'b1, 100, -1, -1, 1'b0, '0, ntx, nd, ec);
        vec++; if (ntx != 72 || nd != 1 || ec != 73) begin
            errs++; $display("FAIL n64_run: %0d transfers %0d dones end %0d, required 72 1 73", ntx, nd, ec);
        end
        for (int i = 0; i < 72; i++) begin
            vec++; if (got_k[i] !== exp_k[i]) begin errs++; $display("FAIL n64_key[%0d]: got %0h required %0h", i, got_k[i], exp_k[i]); end
        end
        encrypt(64, 72, 64'h74206e69206d6f6f, 64'h6d69732061207369, cx, cy);
        vec++; if ({cx, cy} !== {64'h8d2b5579afc8a3a0, 64'h3bf72a87efe7b868}) begin
            errs++; $display("FAIL n64_cipher: got %0h_%0h required 8d2b5579afc8a3a0_3bf72a87efe7b868", cx, cy);
        end
    endtask

    task automatic test_backpressure();
        int ntx, nd, ec;
        logic [255:0] k = {160'd0, $urandom, $urandom, $urandom};
        sel = 2;
        model(2, k);
        collect(k, 1'b1, 50, -1, -1, 1'b0, '0, ntx, nd, ec);
        vec++; if (ntx != 42 || nd != 1) begin errs++; $display("FAIL bp_run: %0d transfers %0d dones, required 42 1", ntx, nd); end
        for (int i = 0; i < 42; i++) begin
            vec++; if (got_k[i] !== exp_k[i]) begin errs++; $display("FAIL bp_key[%0d]: got %0h required %0h", i, got_k[i], exp_k[i]); end
        end
    endtask

    task automatic test_abort();
        int ntx, nd, ec;
        logic [255:0] k1 = {160'd0, $urandom, $urandom, $urandom};
        logic [255:0] k2 = ~k1;
        sel = 2;
        @(posedge clk); #1; abort_b = 1'b1;
        @(posedge clk); #1; abort_b = 1'b0; start_b = 1'b1; abort_b = 1'b1; key_b = k1;
        @(posedge clk); #1; abort_b = 1'b0; start_b = 1'b0;
        vec++; if (obs_busy !== 1'b0 || obs_valid !== 1'b0) begin
            errs++; $display("FAIL abort_idle: busy=%b valid=%b, required 0 0", obs_busy, obs_valid);
        end
        model(2, k1);
        collect(k1, 1'b1, 100, 10, -1, 1'b0, '0, ntx, nd, ec);
        vec++; if (ntx != 10 || nd != 0 || ec != 12 || obs_valid !== 1'b0) begin
            errs++; $display("FAIL abort_run: %0d transfers %0d dones end %0d valid %b, required 10 0 12 0", ntx, nd, ec, obs_valid);
        end
        for (int i = 0; i < 10; i++) begin
            vec++; if (got_k[i] !== exp_k[i]) begin errs++; $display("FAIL abort_key[%0d]: got %0h required %0h", i, got_k[i], exp_k[i]); end
        end
        model(2, k2);
        collect(k2, 1'b1, 100, -1, -1, 1'b0, '0, ntx, nd, ec);
        vec++; if (ntx != 42 || nd != 1 || got_k[0] !== exp_k[0]) begin
            errs++; $display("FAIL abort_restart: %0d transfers %0d dones rk0 %0h, required 42 1 %0h", ntx, nd, got_k[0], exp_k[0]);
        end
    endtask

    task automatic test_async_reset();
        int ntx, nd, ec;
        logic [255:0] k = {160'd0, $urandom, $urandom, $urandom};
        sel = 2;
        @(posedge clk); #1; start_b = 1'b1; key_b = k; ready_b = 1'b1;
        @(posedge clk); #1; start_b = 1'b0;
        repeat (4) @(posedge clk);
        #3; res = 1'b1;
        #1;
        vec++; if ({obs_busy, obs_done, obs_valid, obs_idx, obs_data} !== '0) begin
            errs++; $display("FAIL async_reset: busy=%b done=%b valid=%b idx=%0d data=%0h, required all 0",
                             obs_busy, obs_done, obs_valid, obs_idx, obs_data);
        end
        @(posedge clk); #1; res = 1'b0;
        model(2, k);
        collect(k, 1'b1, 100, -1, -1, 1'b0, '0, ntx, nd, ec);
        vec++; if (ntx != 42 || nd != 1 || ec != 43) begin
            errs++; $display("FAIL post_reset_run: %0d transfers %0d dones end %0d, required 42 1 43", ntx, nd, ec);
        end
        for (int i = 0; i < 42; i++) begin
            vec++; if (got_k[i] !== exp_k[i]) begin errs++; $display("FAIL post_reset_key[%0d]: got %0h required %0h", i, got_k[i], exp_k[i]); end
        end
    endtask

    task automatic test_back_to_back();
        int ntx, nd, ec;
        logic [255:0] k1 = {160'd0, $urandom, $urandom, $urandom};
        logic [255:0] k2 = {160'd0, $urandom, $urandom, $urandom};
        sel = 2;
        model(2, k1);
        collect(k1, 1'b1, 100, -1, 4, 1'b1, k2, ntx, nd, ec);
        vec++; if (ntx != 42 || nd != 1 || ec != 43) begin
            errs++; $display("FAIL b2b_first: %0d transfers %0d dones end %0d, required 42 1 43", ntx, nd, ec);
        end
        for (int i = 0; i < 42; i++) begin
            vec++; if (got_k[i] !== exp_k[i]) begin errs++; $display("FAIL b2b_first_key[%0d]: got %0h required %0h", i, got_k[i], exp_k[i]); end
        end
        model(2, k2);
        collect(k2, 1'b0, 100, -1, -1, 1'b0, '0, ntx, nd, ec);
        vec++; if (ntx != 42 || nd != 1 || ec != 43) begin
            errs++; $display("FAIL b2b_second: %0d transfers %0d dones end %0d, required 42 1 43", ntx, nd, ec);
        end
        for (int i = 0; i < 42; i++) begin
            vec++; if (got_k[i] !== exp_k[i]) begin errs++; $display("FAIL b2b_second_key[%0d]: got %0h required %0h", i, got_k[i], exp_k[i]); end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        res = 1'b1; start_b = 1'b0; abort_b = 1'b0; ready_b = 1'b0; key_b = '0; sel = 0;
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        res = 1'b0;
        test_n16();
        test_n64();
        test_backpressure();
        test_abort();
        test_async_reset();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
